uart_tx_fifo: RTL

//  Byte-serial UART transmitter with an elastic FIFO for the GPSDO monitor link.

---
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side and line-side signals of the UART transmitter.
//   wr_en/wr_data   upstream byte strobe and data
//   TXD             serial line, idle high
//   busy            frame on the line
//   fifo_full/empty FIFO occupancy flags
//   overflow        sticky write-while-full indication
// master: upstream producer; slave: uart_tx_fifo.
interface uart_tx_fifo_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       TXD;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  modport master (output wr_en, wr_data,
                  input  TXD, busy, fifo_full, fifo_empty, overflow);
  modport slave  (input  wr_en, wr_data,
                  output TXD, busy, fifo_full, fifo_empty, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-serial UART transmitter with a 2**FIFO_AW byte FIFO.
// Frames are 8N1, LSB first. Back-to-back frames are sent with no idle gap.
// Optional even parity bit between data and stop when UART_PARITY_EN is defined.
// Ports:
//   CLK_Sys  system clock (CLK_FREQ Hz)
//   CLK_Rst  asynchronous active-low reset; aborts any frame, empties FIFO
//   bus      uart_tx_fifo_if.slave (wr_en, wr_data in; TXD, busy, fifo_full,
//            fifo_empty, overflow out)
module uart_tx_fifo #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 115_200,
  parameter int FIFO_AW  = 4
) (
  input  logic          CLK_Sys,
  input  logic          CLK_Rst,
  uart_tx_fifo_if.slave bus
);
  localparam int BIT_DIV = (CLK_FREQ + BAUD/2) / BAUD;
  localparam int CW      = $clog2(BIT_DIV);
  localparam int DEPTH_N = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH    = (FIFO_AW+1)'(DEPTH_N);
  localparam logic [CW-1:0]    BIT_LAST = CW'(BIT_DIV - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO
  logic [7:0]         mem [DEPTH_N];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, push, pop, ovf;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign push  = bus.wr_en & ~full;

  always_ff @(posedge CLK_Sys)
    if (push) mem[wr_ptr] <= bus.wr_data;

  always_ff @(posedge CLK_Sys or negedge CLK_Rst)
    if (!CLK_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push && !pop)      count <= count + (FIFO_AW+1)'(1);
      else if (pop && !push) count <= count - (FIFO_AW+1)'(1);
      // A pop in the same cycle does not rescue a write that found the FIFO full.
      if (bus.wr_en && full) ovf <= 1'b1;
    end

  // Transmit FSM and datapath
  state_t        state, state_nx;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [CW-1:0] baud_cnt;
  logic          bit_end, txd_d, busy_d, txd_q, busy_q;
`ifdef UART_PARITY_EN
  logic          par;
`endif

  assign bit_end = (baud_cnt == BIT_LAST);

  always_ff @(posedge CLK_Sys or negedge CLK_Rst)
    if (!CLK_Rst) state <= IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (!empty) state_nx = START;
      START: if (bit_end) state_nx = DATA;
`ifdef UART_PARITY_EN
      DATA:   if (bit_end && bit_idx == 3'd7) state_nx = PARITY;
      PARITY: if (bit_end) state_nx = STOP;
`else
      DATA:  if (bit_end && bit_idx == 3'd7) state_nx = STOP;
`endif
      STOP:  if (bit_end) state_nx = empty ? IDLE : START;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    txd_d  = 1'b1;
    busy_d = 1'b1;
    case (state)
      IDLE:   begin busy_d = 1'b0; pop = ~empty; end
      START:  txd_d = 1'b0;
      DATA:   txd_d = shift[0];
`ifdef UART_PARITY_EN
      PARITY: txd_d = par;
`endif
      STOP:   pop = bit_end & ~empty;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_Sys or negedge CLK_Rst)
    if (!CLK_Rst) begin
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
`ifdef UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (pop) begin
      shift    <= mem[rd_ptr];
      bit_idx  <= '0;
      baud_cnt <= '0;
`ifdef UART_PARITY_EN
      par      <= ^mem[rd_ptr];
`endif
    end else if (state != IDLE) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
      if (state == DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end

  // Line outputs are registered one cycle behind the state; reset forces
  // TXD high asynchronously so an aborted frame never leaves the line low.
  always_ff @(posedge CLK_Sys or negedge CLK_Rst)
    if (!CLK_Rst) begin
      txd_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      txd_q  <= txd_d;
      busy_q <= busy_d;
    end

  assign bus.TXD        = txd_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = ovf;
endmodule
